gm64_reset_seq: RTL and testbench

- Parametrised successor to the single-output board reset block.
- Merges the global configuration reset, the debounced user button, PLL lock and a software reset request.
- Produces NUM_CH active-low resets released in a fixed order, so the PLL-clocked video, CPU and memory domains leave reset one stage apart.
- Sits in gm64 between the PLL/button inputs and all functional blocks; reports lock-loss events for debug.

---
 rtl/gm64_reset_seq_pkg.sv | 18 +
 rtl/gm64_debounce.sv | 43 ++++
 rtl/gm64_reset_seq.sv | 132 +++++++++++++
 tb/tb_gm64_reset_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gm64_reset_seq_pkg.sv
// Shared definitions for the gm64 reset sequencer: FSM state encodings,
// debug counter width and the saturating increment used for lock-loss events.
package gm64_reset_seq_pkg;

    localparam int unsigned STATE_W    = 2;
    localparam int unsigned LOCK_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } seq_state_e;

    function automatic logic [LOCK_CNT_W-1:0] sat_inc(input logic [LOCK_CNT_W-1:0] v);
        return (v == '1) ? v : v + LOCK_CNT_W'(1);
    endfunction

endpackage

// File: rtl/gm64_debounce.sv
// Two-flop synchroniser plus stability counter for an active-low push button.
// The accepted level only flips after DEB_CYCLES consecutive differing samples.
module gm64_debounce #(
    parameter int unsigned DEB_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int unsigned    CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    // Sync flops and accepted level reset to the idle (released) button level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign dout = r_level;

endmodule

// File: rtl/gm64_reset_seq.sv
// Board reset sequencer: merges config reset, button, PLL lock and software
// request, then releases NUM_CH active-low resets one stage apart.
module gm64_reset_seq
    import gm64_reset_seq_pkg::*;
#(
    parameter int unsigned NUM_CH       = 3,
    parameter int unsigned DEB_CYCLES   = 100000,
    parameter int unsigned HOLD_CYCLES  = 1024,
    parameter int unsigned STAGE_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fpga_but1,
    input  logic                  pll_locked,
    input  logic                  sw_reset_req,
    output logic [NUM_CH-1:0]     rst_n,
    output logic                  rst_active,
    output logic [STATE_W-1:0]    seq_state,
    output logic [LOCK_CNT_W-1:0] lock_loss_cnt
);

    localparam int unsigned      HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned      STAGE_W    = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_CYCLES - 1);

    logic                  r_lock_s1;
    logic                  r_lock_s;
    seq_state_e            r_state;
    logic [NUM_CH-1:0]     r_rst_n;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [STAGE_W-1:0]    r_stage_cnt;
    logic [LOCK_CNT_W-1:0] r_lock_loss_cnt;

    logic                  w_btn_level;
    logic                  w_trigger;
    logic [NUM_CH-1:0]     w_rst_shift;
    seq_state_e            w_state_nxt;
    logic [NUM_CH-1:0]     w_rst_n_nxt;
    logic [HOLD_W-1:0]     w_hold_nxt;
    logic [STAGE_W-1:0]    w_stage_nxt;
    logic [LOCK_CNT_W-1:0] w_lock_cnt_nxt;

    gm64_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_deb (
        .clk   (clk),
        .reset (reset),
        .din   (fpga_but1),
        .dout  (w_btn_level)
    );

    assign w_trigger   = ~w_btn_level | ~r_lock_s | sw_reset_req;
    // Release order is a thermometer code, so the next channel is a left shift
    assign w_rst_shift = (r_rst_n << 1) | NUM_CH'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lock_s1       <= 1'b0;
            r_lock_s        <= 1'b0;
            r_state         <= ST_ASSERT;
            r_rst_n         <= '0;
            r_hold_cnt      <= '0;
            r_stage_cnt     <= '0;
            r_lock_loss_cnt <= '0;
        end else begin
            r_lock_s1       <= pll_locked;
            r_lock_s        <= r_lock_s1;
            r_state         <= w_state_nxt;
            r_rst_n         <= w_rst_n_nxt;
            r_hold_cnt      <= w_hold_nxt;
            r_stage_cnt     <= w_stage_nxt;
            r_lock_loss_cnt <= w_lock_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rst_n_nxt    = r_rst_n;
        w_hold_nxt     = r_hold_cnt;
        w_stage_nxt    = r_stage_cnt;
        w_lock_cnt_nxt = r_lock_loss_cnt;

        case (r_state)
            ST_ASSERT: begin
                w_rst_n_nxt = '0;
                if (w_trigger) begin
                    w_hold_nxt = '0;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_rst_n_nxt = NUM_CH'(1);
                    w_stage_nxt = '0;
                    w_hold_nxt  = '0;
                    w_state_nxt = (NUM_CH == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            ST_RELEASE, ST_RUN: begin
                if (w_trigger) begin
                    // Abort: only a lost lock is counted, however many triggers coincide
                    w_rst_n_nxt = '0;
                    w_hold_nxt  = '0;
                    w_state_nxt = ST_ASSERT;
                    if (!r_lock_s) begin
                        w_lock_cnt_nxt = sat_inc(r_lock_loss_cnt);
                    end
                end else if (r_state == ST_RUN) begin
                    w_rst_n_nxt = '1;
                end else if (r_stage_cnt == STAGE_LAST) begin
                    w_rst_n_nxt = w_rst_shift;
                    w_stage_nxt = '0;
                    if (&w_rst_shift) begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_stage_nxt = r_stage_cnt + STAGE_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_ASSERT;
                w_rst_n_nxt = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    assign rst_n         = r_rst_n;
    assign rst_active    = ~&r_rst_n;
    assign seq_state     = r_state;
    assign lock_loss_cnt = r_lock_loss_cnt;

endmodule

// File: tb/tb_gm64_reset_seq.sv
// Directed self-checking bench for gm64_reset_seq with short debounce/hold/stage
// settings; inputs change 1 ns after a rising edge and outputs are read there too.
module tb_gm64_reset_seq;

    logic       clk;
    logic       reset;
    logic       fpga_but1;
    logic       pll_locked;
    logic       sw_reset_req;
    logic [2:0] rst_n;
    logic       rst_active;
    logic [1:0] seq_state;
    logic [7:0] lock_loss_cnt;

    int n_checks = 0;
    int n_errors = 0;

    gm64_reset_seq #(
        .NUM_CH       (3),
        .DEB_CYCLES   (4),
        .HOLD_CYCLES  (8),
        .STAGE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fpga_but1     (fpga_but1),
        .pll_locked    (pll_locked),
        .sw_reset_req  (sw_reset_req),
        .rst_n         (rst_n),
        .rst_active    (rst_active),
        .seq_state     (seq_state),
        .lock_loss_cnt (lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; fpga_but1 = 1'b1; pll_locked = 1'b1; sw_reset_req = 1'b0;
        tick(3);
        n_checks++;
        if (rst_n !== 3'b000) begin n_errors++; $display("FAIL reset_rst_n: got %b expected %b", rst_n, 3'b000); end
        n_checks++;
        if (rst_active !== 1'b1) begin n_errors++; $display("FAIL reset_active: got %b expected 1", rst_active); end
        n_checks++;
        if (seq_state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", seq_state); end
        n_checks++;
        if (lock_loss_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_lock_cnt: got %0d expected 0", lock_loss_cnt); end
    endtask

    task automatic test_power_up();
        logic [2:0] exp;
        reset = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            tick(1);
            exp = (e < 10) ? 3'b000 : (e < 14) ? 3'b001 : (e < 18) ? 3'b011 : 3'b111;
            n_checks++;
            if (rst_n !== exp) begin n_errors++; $display("FAIL pwr_rst_n edge %0d: got %b expected %b", e, rst_n, exp); end
            n_checks++;
            if (rst_active !== (e < 18)) begin n_errors++; $display("FAIL pwr_active edge %0d: got %b expected %b", e, rst_active, (e < 18)); end
        end
        n_checks++;
        if (seq_state !== 2'd2) begin n_errors++; $display("FAIL pwr_state: got %0d expected 2", seq_state); end
    endtask

    task automatic test_sw_req();
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        n_checks++;
        if (rst_n !== 3'b000) begin n_errors++; $display("FAIL sw_abort_rst_n: got %b expected 000", rst_n); end
        n_checks++;
        if (seq_state !== 2'd0) begin n_errors++; $display("FAIL sw_abort_state: got %0d expected 0", seq_state); end
        n_checks++;
        if (lock_loss_cnt !== 8'd0) begin n_errors++; $display("FAIL sw_lock_cnt: got %0d expected 0", lock_loss_cnt); end
        // hold count reaches 5, then a second pulse restarts the window
        tick(5);
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        tick(7);
        n_checks++;
        if (rst_n !== 3'b000) begin n_errors++; $display("FAIL sw_restart_hold: got %b expected 000", rst_n); end
        tick(1);
        n_checks++;
        if (rst_n !== 3'b001) begin n_errors++; $display("FAIL sw_restart_release: got %b expected 001", rst_n); end
        n_checks++;
        if (seq_state !== 2'd1) begin n_errors++; $display("FAIL sw_release_state: got %0d expected 1", seq_state); end
        tick(8);
        n_checks++;
        if (rst_n !== 3'b111 || seq_state !== 2'd2) begin n_errors++; $display("FAIL sw_run: got %b/%0d expected 111/2", rst_n, seq_state); end
    endtask

    task automatic test_button();
        logic bounce [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            fpga_but1 = bounce[i];
            tick(1);
            n_checks++;
            if (rst_n !== 3'b111) begin n_errors++; $display("FAIL btn_bounce step %0d: got %b expected 111", i, rst_n); end
        end
        fpga_but1 = 1'b1;
        tick(8);
        n_checks++;
        if (rst_n !== 3'b111) begin n_errors++; $display("FAIL btn_bounce_settle: got %b expected 111", rst_n); end
        fpga_but1 = 1'b0;
        tick(6);
        n_checks++;
        if (rst_n !== 3'b111) begin n_errors++; $display("FAIL btn_before_accept: got %b expected 111", rst_n); end
        fpga_but1 = 1'b1;
        tick(1);
        n_checks++;
        if (rst_n !== 3'b000) begin n_errors++; $display("FAIL btn_abort: got %b expected 000", rst_n); end
        n_checks++;
        if (lock_loss_cnt !== 8'd0) begin n_errors++; $display("FAIL btn_lock_cnt: got %0d expected 0", lock_loss_cnt); end
        // debounced release lands 5 edges later, then the 8-cycle hold
        tick(12);
        n_checks++;
        if (rst_n !== 3'b000) begin n_errors++; $display("FAIL btn_hold: got %b expected 000", rst_n); end
        tick(1);
        n_checks++;
        if (rst_n !== 3'b001 || seq_state !== 2'd1) begin n_errors++; $display("FAIL btn_rerelease: got %b/%0d expected 001/1", rst_n, seq_state); end
    endtask

    task automatic test_lock_loss();
        int exp_cnt;
        pll_locked = 1'b0;
        tick(2);
        n_checks++;
        if (rst_n !== 3'b001) begin n_errors++; $display("FAIL lock_sync_delay: got %b expected 001", rst_n); end
        tick(1);
        n_checks++;
        if (rst_n !== 3'b000 || seq_state !== 2'd0) begin n_errors++; $display("FAIL lock_abort: got %b/%0d expected 000/0", rst_n, seq_state); end
        n_checks++;
        if (lock_loss_cnt !== 8'd1) begin n_errors++; $display("FAIL lock_cnt_first: got %0d expected 1", lock_loss_cnt); end
        tick(7);
        pll_locked = 1'b1;
        tick(9);
        n_checks++;
        if (rst_n !== 3'b000) begin n_errors++; $display("FAIL lock_relock_hold: got %b expected 000", rst_n); end
        n_checks++;
        if (lock_loss_cnt !== 8'd1) begin n_errors++; $display("FAIL lock_cnt_in_assert: got %0d expected 1", lock_loss_cnt); end
        tick(1);
        n_checks++;
        if (rst_n !== 3'b001) begin n_errors++; $display("FAIL lock_relock_release: got %b expected 001", rst_n); end
        for (int i = 2; i <= 300; i++) begin
            pll_locked = 1'b0;
            tick(3);
            pll_locked = 1'b1;
            exp_cnt = (i > 255) ? 255 : i;
            n_checks++;
            if (lock_loss_cnt !== 8'(exp_cnt)) begin n_errors++; $display("FAIL lock_cnt iter %0d: got %0d expected %0d", i, lock_loss_cnt, exp_cnt); end
            tick(10);
        end
        n_checks++;
        if (rst_n !== 3'b001 || lock_loss_cnt !== 8'd255) begin n_errors++; $display("FAIL lock_saturate: got %b/%0d expected 001/255", rst_n, lock_loss_cnt); end
    endtask

    task automatic test_async_reset();
        tick(4);
        n_checks++;
        if (rst_n !== 3'b011) begin n_errors++; $display("FAIL async_pre: got %b expected 011", rst_n); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (rst_n !== 3'b000 || seq_state !== 2'd0) begin n_errors++; $display("FAIL async_reset: got %b/%0d expected 000/0", rst_n, seq_state); end
        n_checks++;
        if (lock_loss_cnt !== 8'd0 || rst_active !== 1'b1) begin n_errors++; $display("FAIL async_cnt: got %0d/%b expected 0/1", lock_loss_cnt, rst_active); end
        tick(2);
        reset = 1'b1;
        tick(9);
        n_checks++;
        if (rst_n !== 3'b000) begin n_errors++; $display("FAIL async_restart_hold: got %b expected 000", rst_n); end
        tick(1);
        n_checks++;
        if (rst_n !== 3'b001) begin n_errors++; $display("FAIL async_restart_release: got %b expected 001", rst_n); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_sw_req();
        test_button();
        test_lock_loss();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
